// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and op decode for the trace driver.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W = 48;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for the two ops the cache understands.
    function automatic logic op_is_valid(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/trace_driver_if.sv
// Load (record in) and cache (op out) handshake channels of the trace driver.
interface trace_driver_if #(
    parameter int unsigned ADDR_W = cache_pkg::DEF_ADDR_W
) ();

    logic              load_valid;
    logic              load_ready;
    logic [7:0]        load_op;
    logic [ADDR_W-1:0] load_addr;
    logic              load_last;

    logic              cache_valid;
    logic              cache_ready;
    logic [ADDR_W-1:0] cache_addr;
    logic [7:0]        cache_op;

    // Trace source and cache model side.
    modport master (
        output load_valid, load_op, load_addr, load_last, cache_ready,
        input  load_ready, cache_valid, cache_addr, cache_op
    );

    // Trace driver side.
    modport slave (
        input  load_valid, load_op, load_addr, load_last, cache_ready,
        output load_ready, cache_valid, cache_addr, cache_op
    );

endinterface

// File: rtl/trace_fifo.sv
// Record buffer: FIFO with wrap-bit pointers, zero head output when empty.
module trace_fifo #(
    parameter int unsigned WIDTH = 56,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level   = wr_q - rd_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/trace_driver.sv
// Buffers trace records and replays them to a cache under a start/run/done FSM.
module trace_driver
    import cache_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned CNT_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    trace_driver_if.slave     bus,
    output logic [CNT_W-1:0]  ops_read,
    output logic [CNT_W-1:0]  ops_write,
    output logic [CNT_W-1:0]  ops_dropped,
    output logic              busy,
    output logic              done
);

    localparam int unsigned REC_W = 8 + ADDR_W;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic              last_seen_q;
    logic [CNT_W-1:0]  ops_read_q;
    logic [CNT_W-1:0]  ops_write_q;
    logic [CNT_W-1:0]  ops_dropped_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [REC_W-1:0]  fifo_dout;
    logic              accept;
    logic              op_ok;
    logic              push;
    logic              pop;
    logic              restart;
    logic              drain_done;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign bus.load_ready  = !fifo_full;
    assign accept          = bus.load_valid && !fifo_full;
    assign op_ok           = op_is_valid(bus.load_op);
    assign push            = accept && op_ok;
    assign bus.cache_valid = (state_q == ST_RUN) && !fifo_empty;
    assign pop             = bus.cache_valid && bus.cache_ready;
    assign {bus.cache_op, bus.cache_addr} = fifo_dout;
    assign restart         = (state_q == ST_DONE) && start;
    // Drained: buffer already empty, or the final record leaves this cycle.
    assign drain_done      = last_seen_q && !push &&
                             (fifo_empty || (pop && (fifo_level == LVL_W'(1))));

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign ops_read    = ops_read_q;
    assign ops_write   = ops_write_q;
    assign ops_dropped = ops_dropped_q;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({bus.load_op, bus.load_addr}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Playback FSM, last-record flag and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_seen_q   <= 1'b0;
            ops_read_q    <= '0;
            ops_write_q   <= '0;
            ops_dropped_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start)      state_q <= ST_RUN;
                ST_RUN:  if (drain_done) state_q <= ST_DONE;
                ST_DONE: if (start)      state_q <= ST_RUN;
                default:                 state_q <= ST_IDLE;
            endcase

            if (accept && bus.load_last) begin
                last_seen_q <= 1'b1;
            end else if (restart) begin
                last_seen_q <= 1'b0;
            end

            if (accept && !op_ok) begin
                ops_dropped_q <= sat_inc(restart ? CNT_W'(0) : ops_dropped_q);
            end else if (restart) begin
                ops_dropped_q <= '0;
            end

            if (restart) begin
                ops_read_q  <= '0;
                ops_write_q <= '0;
            end else if (pop) begin
                if (bus.cache_op == OP_READ) begin
                    ops_read_q <= sat_inc(ops_read_q);
                end else begin
                    ops_write_q <= sat_inc(ops_write_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_driver.sv
// Directed and random playback checks against a queue-based reference model.
module tb_trace_driver;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 48;
    localparam int unsigned CW    = 12;
    localparam int          SATV  = (1 << CW) - 1;

    typedef struct {
        logic [7:0]    op;
        logic [AW-1:0] addr;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] ops_read;
    logic [CW-1:0] ops_write;
    logic [CW-1:0] ops_dropped;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of stored records, state 0 idle / 1 run / 2 done.
    rec_t mq[$];
    int   ms;
    bit   mlast;
    int   mrd, mwr, mdrop;

    always #5 clk = ~clk;

    trace_driver_if #(.ADDR_W(AW)) bus ();

    trace_driver #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .ops_read    (ops_read),
        .ops_write   (ops_write),
        .ops_dropped (ops_dropped),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SATV) ? SATV : v;
    endfunction

    task automatic check_outputs();
        logic [AW-1:0] ea;
        logic [7:0]    eo;
        ea = '0;
        eo = '0;
        if (mq.size() > 0) begin
            ea = mq[0].addr;
            eo = mq[0].op;
        end
        chk("load_ready",  64'(bus.load_ready),  64'(mq.size() < int'(DEPTH)));
        chk("cache_valid", 64'(bus.cache_valid), 64'((ms == 1) && (mq.size() > 0)));
        chk("cache_addr",  64'(bus.cache_addr),  64'(ea));
        chk("cache_op",    64'(bus.cache_op),    64'(eo));
        chk("busy",        64'(busy),            64'(ms == 1));
        chk("done",        64'(done),            64'(ms == 2));
        chk("ops_read",    64'(ops_read),        64'(sat(mrd)));
        chk("ops_write",   64'(ops_write),       64'(sat(mwr)));
        chk("ops_dropped", 64'(ops_dropped),     64'(sat(mdrop)));
    endtask

    // Advance the model by one clock from the current inputs, then clock the DUT and compare.
    task automatic cycle();
        bit   acc, okop, pop, lastb, restart;
        rec_t r;
        if (reset) begin
            mq.delete();
            ms = 0; mlast = 0; mrd = 0; mwr = 0; mdrop = 0;
        end else begin
            acc     = bus.load_valid && (mq.size() < int'(DEPTH));
            okop    = (bus.load_op == 8'h52) || (bus.load_op == 8'h57);
            pop     = (ms == 1) && (mq.size() > 0) && bus.cache_ready;
            lastb   = mlast;
            restart = (ms == 2) && start;
            if (restart) begin
                mrd = 0; mwr = 0; mdrop = 0; mlast = 0;
            end
            if (pop) begin
                r = mq.pop_front();
                if (r.op == 8'h52) mrd++;
                else               mwr++;
            end
            if (acc) begin
                if (okop) begin
                    r.op   = bus.load_op;
                    r.addr = bus.load_addr;
                    mq.push_back(r);
                end else begin
                    mdrop++;
                end
                if (bus.load_last) mlast = 1;
            end
            case (ms)
                0: if (start) ms = 1;
                1: if (lastb && mq.size() == 0) ms = 2;
                2: if (start) ms = 1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic load(input bit v, input logic [7:0] op, input logic [AW-1:0] a, input bit l);
        bus.load_valid = v;
        bus.load_op    = op;
        bus.load_addr  = a;
        bus.load_last  = l;
    endtask

    function automatic logic [AW-1:0] raddr();
        return AW'({$urandom(), $urandom()});
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.cache_ready = 1'b0;
        load(0, 8'h00, '0, 0);
        ms = 0; mlast = 0; mrd = 0; mwr = 0; mdrop = 0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("ready_after_reset", 64'(bus.load_ready), 64'(1));

        // Two-record trace plays in order and finishes right after the last pop.
        load(1, 8'h52, AW'(48'h1000), 0); cycle();
        load(1, 8'h57, AW'(48'h2000), 1); cycle();
        load(0, 8'h00, '0, 0);
        start = 1'b1; cycle();
        start = 1'b0; bus.cache_ready = 1'b1;
        chk("first_addr", 64'(bus.cache_addr), 64'h1000);
        chk("first_op",   64'(bus.cache_op),   64'h52);
        cycle();
        chk("second_addr", 64'(bus.cache_addr), 64'h2000);
        cycle();
        chk("basic_done",  64'(done),      64'(1));
        chk("basic_reads", 64'(ops_read),  64'(1));
        chk("basic_write", 64'(ops_write), 64'(1));

        // Stalled cache holds the head; restart from DONE clears counters.
        bus.cache_ready = 1'b0;
        load(1, 8'h57, AW'(48'hABC0), 0); cycle();
        load(0, 8'h00, '0, 0);
        start = 1'b1; cycle();
        start = 1'b0;
        chk("restart_clear", 64'(ops_read), 64'(0));
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_addr", 64'(bus.cache_addr), 64'hABC0);
            chk("stall_op",   64'(bus.cache_op),   64'h57);
        end
        reset = 1'b1; cycle(); reset = 1'b0; cycle();

        // Fill to depth in IDLE; ninth record waits for a pop.
        for (int i = 0; i < 8; i++) begin
            load(1, ($urandom_range(0, 1) != 0) ? 8'h52 : 8'h57, raddr(), 0);
            cycle();
        end
        chk("full_not_ready", 64'(bus.load_ready), 64'(0));
        load(1, 8'h52, AW'(48'h9999), 1); cycle();
        start = 1'b1; cycle();
        start = 1'b0; bus.cache_ready = 1'b1; cycle();
        chk("ready_after_pop", 64'(bus.load_ready), 64'(1));
        cycle();
        load(0, 8'h00, '0, 0);
        for (int i = 0; i < 10; i++) cycle();
        chk("fill_done",  64'(done), 64'(1));
        chk("fill_total", 64'(ops_read) + 64'(ops_write), 64'(9));

        // Invalid op with last on empty buffer: dropped, run ends at once.
        reset = 1'b1; cycle(); reset = 1'b0;
        load(1, 8'h58, raddr(), 1); cycle();
        load(0, 8'h00, '0, 0);
        chk("drop_count", 64'(ops_dropped), 64'(1));
        start = 1'b1; cycle();
        start = 1'b0;
        chk("drop_busy", 64'(busy), 64'(1));
        cycle();
        chk("drop_done", 64'(done), 64'(1));

        // Reset mid-run beats simultaneous start, load and cache handshakes.
        reset = 1'b1; cycle(); reset = 1'b0;
        bus.cache_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load(1, 8'h57, raddr(), 0); cycle();
        end
        load(0, 8'h00, '0, 0);
        start = 1'b1; cycle();
        start = 1'b0;
        reset = 1'b1; start = 1'b1; bus.cache_ready = 1'b1;
        load(1, 8'h52, raddr(), 1);
        cycle();
        chk("rst_valid", 64'(bus.cache_valid), 64'(0));
        chk("rst_busy",  64'(busy),            64'(0));
        chk("rst_write", 64'(ops_write),       64'(0));
        reset = 1'b0; start = 1'b0;
        load(0, 8'h00, '0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic including occasional resets and restarts.
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel   = int'($urandom_range(0, 9));
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 15) == 0);
            bus.cache_ready = ($urandom_range(0, 2) != 0);
            load($urandom_range(0, 1) != 0,
                 (sel < 5) ? 8'h52 : (sel < 9) ? 8'h57 : 8'($urandom_range(0, 255)),
                 raddr(), $urandom_range(0, 19) == 0);
            cycle();
        end

        // Long read stream drives ops_read into saturation.
        reset = 1'b1; start = 1'b0; load(0, 8'h00, '0, 0); cycle();
        reset = 1'b0; start = 1'b1; cycle();
        start = 1'b0; bus.cache_ready = 1'b1;
        load(1, 8'h52, AW'(48'h40), 0);
        for (int i = 0; i < 4105; i++) cycle();
        chk("read_saturate", 64'(ops_read), 64'(4095));
        chk("sat_dropped",   64'(ops_dropped), 64'(0));
        load(0, 8'h00, '0, 0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_driver.md
TRACE_DRIVER -- requirements
Module: trace_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: record buffer depth, power of two, at least 2.
REQ-002 Parameter ADDR_W, default 48: address width.
REQ-003 Parameter CNT_W, default 12: statistics counter width.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins or restarts trace playback.
REQ-007 load_valid  input  1  a trace record is offered on load_op/load_addr/load_last.
REQ-008 load_ready  output  1  driver accepts the offered record this cycle.
REQ-009 load_op  input  8  ASCII op: 8'h52 'R' or 8'h57 'W'.
REQ-010 load_addr  input  ADDR_W  byte address of the record.
REQ-011 load_last  input  1  marks the final record of the trace.
REQ-012 cache_valid  output  1  an op is presented to the cache.
REQ-013 cache_ready  input  1  cache accepts the presented op this cycle.
REQ-014 cache_addr  output  ADDR_W  address presented to the cache.
REQ-015 cache_op  output  8  op presented to the cache.
REQ-016 ops_read, ops_write, ops_dropped  output  CNT_W each  counts of issued reads, issued writes and rejected records.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.

Function
REQ-019 A record SHALL be accepted when load_valid && load_ready; load_ready = buffer not full, independent of FSM state.
REQ-020 An accepted record whose load_op is not 8'h52 or 8'h57 SHALL NOT be stored; ops_dropped SHALL increment instead.
REQ-021 load_last on any accepted record, stored or dropped, SHALL set the last_seen flag.
REQ-022 Buffer SHALL be FIFO-ordered, with no bypass; minimum latency from acceptance to cache_valid is 1 cycle.
REQ-023 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-024 FSM states: IDLE, RUN, DONE.
REQ-025 IDLE -> RUN on start.
REQ-026 RUN -> DONE when last_seen is set and the buffer is empty, including the cycle after the final pop.
REQ-027 DONE -> RUN on start; this SHALL clear last_seen and all three counters in the same cycle.
REQ-028 start SHALL be ignored in RUN.
REQ-029 cache_valid = (state == RUN) && buffer not empty; cache_addr and cache_op SHALL show the buffer head.
REQ-030 A pop SHALL occur only on cache_valid && cache_ready.
REQ-031 Head outputs SHALL stay stable while cache_valid && !cache_ready.
REQ-032 On each pop, ops_read or ops_write SHALL increment according to the popped op.
REQ-033 All counters SHALL saturate at 2^CNT_W-1 (4095) and never wrap.
REQ-034 Buffer pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-035 Records loaded in IDLE or DONE SHALL be buffered and held until RUN.

Reset
REQ-036 Reset SHALL return the FSM to IDLE, empty the buffer and clear last_seen.
REQ-037 During and after reset: cache_valid=0, cache_addr=0, cache_op=8'h00, all counters=0, busy=0, done=0.
REQ-038 load_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-039 Reset mid-playback SHALL discard buffered records without issuing them.
REQ-040 Reset SHALL take priority over start, load and cache handshakes in the same cycle.

Structure
REQ-041 Shared package cache_pkg SHALL hold OP_READ=8'h52, OP_WRITE=8'h57, the FSM state enum and the default ADDR_W.
REQ-042 The buffer SHALL be a sub-module trace_fifo (parameters: width, depth) with ports push, pop, din, dout, full, empty.

Verification
REQ-043 Load R@0x1000, W@0x2000 (last); start; cache_ready=1 -> two cache_valid cycles in order; ops_read=1, ops_write=1; done=1 the cycle after the second pop.
REQ-044 Hold cache_ready=0 for 5 cycles with a record present -> cache_addr/cache_op unchanged; no pop; counters unchanged.
REQ-045 Load 9 records with FIFO_DEPTH=8 while in IDLE -> load_ready=0 after the 8th; start and pop one -> load_ready=1 and the 9th is accepted.
REQ-046 Load op 8'h58 with load_last=1 on an empty buffer -> ops_dropped=1; nothing issued; RUN->DONE immediately after start.
REQ-047 Assert reset with 3 records buffered in RUN -> next cycle cache_valid=0, counters=0, state IDLE; no further issue.
REQ-048 Issue 4100 reads -> ops_read saturates at 4095.
